// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: a small FIFO between the rasterizers and the framebuffer
// SRAM write port, with backpressure, duplicate/range filtering and frame_done.
// Ports:
//   clk, rst                        clock, async active-high reset
//   pix_address/pix_valid/pix_color pixel stream from the rasterizer
//   prim_done                       rasterizer finished its primitive
//   stop                            backpressure to the rasterizer
//   mem_addr/mem_data/mem_wen       SRAM write request (FIFO head)
//   mem_ack                         SRAM accepted the current write
//   frame_done                      one-cycle pulse, primitive fully written
//   overflow                        sticky, an accepted pixel was lost
module pixel_write_buffer #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 8,
  parameter int STOP_MARGIN = 2,
  parameter int MAX_ADDR    = 307200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pix_address,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_color,
  input  logic              prim_done,
  output logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wen,
  input  logic              mem_ack,
  output logic              frame_done,
  output logic              overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] STOP_LVL = CW'(DEPTH - STOP_MARGIN);
  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [ADDR_W-1:0] last_addr;
  logic              last_addr_valid;
  logic              done_pending;

  logic cand;
  logic full;
  logic push;
  logic pop;

  // A candidate is a valid, in-range pixel that is not a boundary repeat.
  assign cand = pix_valid && (pix_address < MAX_A) &&
                !(last_addr_valid && (pix_address == last_addr));
  assign full = (count == FULL_LVL);
  assign pop  = (state == WRITE) && mem_ack;
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign push = cand && (!full || pop);

  assign count_next = count + CW'(push) - CW'(pop);

  assign stop       = (count >= STOP_LVL);
  assign mem_wen    = (state == WRITE);
  assign mem_addr   = mem_wen ? addr_mem[rd_ptr] : '0;
  assign mem_data   = mem_wen ? data_mem[rd_ptr] : '0;
  assign frame_done = done_pending && (count == '0) && (state == IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= pix_address;
      data_mem[wr_ptr] <= pix_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      last_addr       <= '0;
      last_addr_valid <= 1'b0;
      done_pending    <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + PW'(1);
        last_addr <= pix_address;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
      state <= (count_next != '0) ? WRITE : IDLE;

      // The next primitive may legitimately start on the same pixel.
      if (prim_done)
        last_addr_valid <= 1'b0;
      else if (push)
        last_addr_valid <= 1'b1;

      if (cand && full && !pop) overflow <= 1'b1;

      if (prim_done)
        done_pending <= 1'b1;
      else if (frame_done)
        done_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer: vector table plus hand-written
// sequences, with a write-port scoreboard fed by a reference acceptance model.
module tb_pixel_write_buffer;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int MAXA   = 307200;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pix_address;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_color;
  logic              prim_done;
  logic              stop;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wen;
  logic              mem_ack;
  logic              frame_done;
  logic              overflow;

  pixel_write_buffer dut (
    .clk(clk), .rst(rst),
    .pix_address(pix_address), .pix_valid(pix_valid),
    .pix_color(pix_color), .prim_done(prim_done),
    .stop(stop), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_wen(mem_wen), .mem_ack(mem_ack),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  typedef struct {
    logic        valid;
    int          addr;
    logic        ack;
    logic        exp_stop;
    logic        exp_ovf;
  } vec_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  mlast  = 0;
  bit  mlast_v = 0;

  // Scoreboard: a write completes at the next edge when wen and ack are high.
  always @(negedge clk) begin
    if (!rst && mem_wen && mem_ack) begin
      wr_t e;
      wr_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0h, none expected",
                 mem_addr, mem_data);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.a || mem_data !== e.d) begin
          errors++;
          $display("FAIL write_order: got %0d/%0h, expected %0d/%0h",
                   mem_addr, mem_data, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] col(input int a);
    logic [31:0] t;
    t = a;
    return t[7:0] ^ 8'h5A;
  endfunction

  // Reference acceptance model, evaluated against the FIFO content that is
  // present just before the coming edge.
  task automatic drive(input logic v, input int a, input logic [7:0] c,
                       input logic pd);
    bit cand;
    pix_valid   = v;
    pix_address = ADDR_W'(a);
    pix_color   = c;
    prim_done   = pd;
    if (v) begin
      cand = (a < MAXA) && !(mlast_v && a == mlast);
      if (cand) begin
        if (sb.size() < DEPTH || (mem_ack && sb.size() > 0)) begin
          sb.push_back('{a: ADDR_W'(a), d: c});
          mlast   = a;
          mlast_v = 1;
        end
      end
    end
    if (pd) mlast_v = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 0, 8'h00, 1'b0);
  endtask

  vec_t vt[16];
  int   w0;

  initial begin
    vt[0]  = '{1, 1000,   1, 0, 0};
    vt[1]  = '{1, 1000,   1, 0, 0};
    vt[2]  = '{1, 307200, 1, 0, 0};
    vt[3]  = '{1, 307199, 1, 0, 0};
    vt[4]  = '{0, 0,      1, 0, 0};
    vt[5]  = '{0, 0,      1, 0, 0};
    vt[6]  = '{0, 0,      0, 0, 0};
    for (int i = 0; i < 9; i++)
      vt[7+i] = '{1, i, 0, (i >= 5 ? 1'b1 : 1'b0), (i == 8 ? 1'b1 : 1'b0)};

    // Reset with toggling inputs
    rst = 1; mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      pix_valid = i[0]; pix_address = ADDR_W'(i*77);
      pix_color = 8'hA5; prim_done = ~i[0];
      step();
      chk("rst_stop", stop, 0);
      chk("rst_wen", mem_wen, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_data", mem_data, 0);
    end
    idle();
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_wen", mem_wen, 0);
      chk("post_rst_fd", frame_done, 0);
      chk("post_rst_stop", stop, 0);
    end

    // Single pixel latency
    drive(1'b1, 153920, 8'hFF, 1'b0);
    step();
    idle();
    chk("lat_wen", mem_wen, 1);
    chk("lat_addr", mem_addr, 153920);
    chk("lat_data", mem_data, 8'hFF);
    step();
    chk("lat_wen_off", mem_wen, 0);

    // Table: duplicate/range filtering then backpressure with ack low
    w0 = wr_cnt;
    for (int i = 0; i < 16; i++) begin
      mem_ack = vt[i].ack;
      drive(vt[i].valid, vt[i].addr, col(vt[i].addr), 1'b0);
      step();
      chk($sformatf("vec%0d_stop", i), stop, vt[i].exp_stop);
      chk($sformatf("vec%0d_ovf", i), overflow, vt[i].exp_ovf);
      if (i == 6) chk("dup_writes", wr_cnt - w0, 2);
    end
    idle();

    // Drain the full FIFO
    w0 = wr_cnt;
    mem_ack = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("drain%0d_stop", k), stop, (8 - k) >= 6);
    end
    chk("drain_writes", wr_cnt - w0, 8);
    chk("drain_wen", mem_wen, 0);
    chk("drain_sb", sb.size(), 0);

    // Done handling
    mem_ack = 0;
    drive(1'b1, 10, col(10), 1'b0); step();
    drive(1'b1, 20, col(20), 1'b0); step();
    drive(1'b1, 30, col(30), 1'b0); step();
    drive(1'b0, 0, 8'h00, 1'b1); step();
    idle();
    chk("done_wait0", frame_done, 0);
    step();
    chk("done_wait1", frame_done, 0);
    mem_ack = 1;
    step(); chk("done_pop1", frame_done, 0);
    step(); chk("done_pop2", frame_done, 0);
    step(); chk("done_pulse", frame_done, 1);
    chk("done_wen", mem_wen, 0);
    step(); chk("done_once", frame_done, 0);
    chk("done_sb", sb.size(), 0);

    // Reset mid-drain
    mem_ack = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 100 + i, col(100 + i), 1'b0);
      step();
    end
    idle();
    chk("pre_rst_wen", mem_wen, 1);
    rst = 1;
    #2;
    chk("mid_rst_wen", mem_wen, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_addr", mem_addr, 0);
    rst = 0;
    sb.delete();
    mlast_v = 0;
    mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("after_rst_wen", mem_wen, 0);
    end
    drive(1'b1, 42, col(42), 1'b0);
    step();
    idle();
    chk("new_wen", mem_wen, 1);
    chk("new_addr", mem_addr, 42);
    chk("new_data", mem_data, col(42));
    step();
    chk("new_done_wen", mem_wen, 0);
    chk("final_sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
